// File: rtl/arm_instr_encoder.sv
// Encodes one mnemonic-level request at a time into the decoder's 32-bit instruction
// format and writes it to instruction memory at an auto-incrementing word address.
module arm_instr_encoder #(
   parameter int          ADDR_W    = 6,
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [3:0]        req_cond,
   input  logic              req_imm,
   input  logic              req_s,
   input  logic [3:0]        req_rn,
   input  logic [3:0]        req_rd,
   input  logic [11:0]       req_op2,
   input  logic [23:0]       req_offset,
   output logic              imem_we,
   output logic [31:0]       imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              err,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_count;
   logic [31:0]       r_word;
   logic              r_err;

   logic [31:0]       w_word;
   logic              w_legal;
   logic              w_xfer;

   // Start from the generic data-processing layout and patch the fields each op overrides.
   always_comb begin
      w_legal = 1'b1;
      w_word  = {req_cond, 2'b00, req_imm, 4'b0000, req_s, req_rn, req_rd, req_op2};
      case (req_op)
         4'd0:  w_word[24:21] = 4'b1101;
         4'd1:  w_word[24:21] = 4'b1111;
         4'd2:  w_word[24:21] = 4'b0100;
         4'd3:  w_word[24:21] = 4'b0101;
         4'd4:  w_word[24:21] = 4'b0010;
         4'd5:  w_word[24:21] = 4'b0110;
         4'd6:  w_word[24:21] = 4'b0000;
         4'd7:  w_word[24:21] = 4'b1100;
         4'd8:  w_word[24:21] = 4'b0001;
         4'd9:  begin
            w_word[24:21] = 4'b1010;
            w_word[20]    = 1'b1;
            w_word[15:12] = 4'b0000;
         end
         4'd10: begin
            w_word[24:21] = 4'b1000;
            w_word[20]    = 1'b1;
            w_word[15:12] = 4'b0000;
         end
         4'd11: w_word[27:20] = 8'b0100_1001;
         4'd12: w_word[27:20] = 8'b0100_1000;
         4'd13: w_word = {req_cond, 4'b1010, req_offset};
         default: w_legal = 1'b0;
      endcase
   end

   assign w_xfer = req_valid && (r_state == S_IDLE);

   // clr outranks the FSM; a WRITE cycle under clr still strobes because imem_we follows state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_count <= '0;
         r_word  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (clr) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_xfer) begin
                     if (w_legal) begin
                        r_word  <= w_word;
                        r_state <= S_WRITE;
                     end else begin
                        r_err <= 1'b1;
                     end
                  end
               end
               S_WRITE: begin
                  r_ptr   <= r_ptr + ADDR_W'(1);
                  r_count <= r_count + (ADDR_W+1)'(1);
                  r_state <= (r_ptr == LAST_PTR) ? S_FULL : S_IDLE;
               end
               S_FULL:  r_state <= S_FULL;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign imem_we    = (r_state == S_WRITE);
   assign imem_addr  = BASE_ADDR + {{(30-ADDR_W){1'b0}}, r_ptr, 2'b00};
   assign imem_wdata = r_word;
   assign err        = r_err;
   assign full       = (r_state == S_FULL);
   assign count      = r_count;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Scoreboard bench for arm_instr_encoder: stimulus pushes expected writes, a negedge
// monitor pops and compares them whenever the encoder strobes imem_we.
module tb_arm_instr_encoder;

   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   logic          clk;
   logic          rst;
   logic          clr;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [3:0]    req_cond;
   logic          req_imm;
   logic          req_s;
   logic [3:0]    req_rn;
   logic [3:0]    req_rd;
   logic [11:0]   req_op2;
   logic [23:0]   req_offset;
   logic          imem_we;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_wdata;
   logic          err;
   logic          full;
   logic [ADDR_W:0] count;

   int vectorsApplied = 0;
   int miscompares    = 0;
   int errPending     = 0;
   int expPtr         = 0;
   logic [63:0] expQ[$];
   logic [63:0] monExp;

   arm_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_cond(req_cond), .req_imm(req_imm), .req_s(req_s),
      .req_rn(req_rn), .req_rd(req_rd), .req_op2(req_op2), .req_offset(req_offset),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .err(err), .full(full), .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench funnels through here so the counters stay in one place.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Waits (bounded) for req_ready, presents one request for one edge, and records what should be written.
   task automatic applyStimulus(input logic [3:0] op, input logic [3:0] cond, input logic imm,
                                input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                input logic [11:0] op2, input logic [23:0] off,
                                input logic expWrite, input logic [31:0] expWord);
      int waitCycles = 0;
      while (!req_ready && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!req_ready) begin
         vectorsApplied++;
         miscompares++;
         $display("[TB] FAIL ready_timeout: req_ready stayed 0 for %0d cycles", waitCycles);
         return;
      end
      req_op = op; req_cond = cond; req_imm = imm; req_s = s;
      req_rn = rn; req_rd = rd; req_op2 = op2; req_offset = off;
      req_valid = 1'b1;
      if (expWrite) begin
         expQ.push_back({32'(expPtr * 4), expWord});
         expPtr++;
      end else begin
         errPending++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Monitor: compares each write strobe against the oldest expected write and accounts err pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_we) begin
            if (expQ.size() == 0) begin
               vectorsApplied++;
               miscompares++;
               $display("[TB] FAIL unexpected_write: addr %08h data %08h, expected no write", imem_addr, imem_wdata);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("imem_addr", imem_addr, monExp[63:32]);
               checkOutput("imem_wdata", imem_wdata, monExp[31:0]);
            end
            if (err) begin
               vectorsApplied++;
               miscompares++;
               $display("[TB] FAIL err_with_we: err=1 imem_we=1, expected err=0 during a write");
            end
         end
         if (err) begin
            if (errPending > 0) errPending--;
            else begin
               vectorsApplied++;
               miscompares++;
               $display("[TB] FAIL unexpected_err: err=1, expected 0");
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b1; clr = 1'b0; req_valid = 1'b0;
      req_op = '0; req_cond = '0; req_imm = 1'b0; req_s = 1'b0;
      req_rn = '0; req_rd = '0; req_op2 = '0; req_offset = '0;
      #12;
      checkOutput("rst_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_we", 32'(imem_we), 32'd0);
      checkOutput("rst_addr", imem_addr, 32'h0);
      checkOutput("rst_wdata", imem_wdata, 32'h0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      applyStimulus(4'd2,  4'hE, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1, 32'hE2821005);
      applyStimulus(4'd9,  4'hE, 1'b0, 1'b0, 4'd3, 4'd7, 12'h004, 24'h0, 1'b1, 32'hE1530004);
      @(posedge clk);
      #1;
      checkOutput("count_after_2", 32'(count), 32'd2);

      // Illegal ops: err pulses exactly one cycle, nothing written, count unchanged.
      applyStimulus(4'd15, 4'hE, 1'b0, 1'b0, 4'd1, 4'd1, 12'h001, 24'h0, 1'b0, 32'h0);
      checkOutput("err_pulse", 32'(err), 32'd1);
      checkOutput("err_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("err_drop", 32'(err), 32'd0);
      checkOutput("count_after_err", 32'(count), 32'd2);
      applyStimulus(4'd14, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h0, 1'b0, 32'h0);
      checkOutput("err_pulse_14", 32'(err), 32'd1);

      applyStimulus(4'd11, 4'hE, 1'b0, 1'b0, 4'd1, 4'd0, 12'h004, 24'h0, 1'b1, 32'hE4910004);
      applyStimulus(4'd13, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 1'b1, 32'hEAFFFFFE);
      @(posedge clk);
      #1;
      checkOutput("full_set", 32'(full), 32'd1);
      checkOutput("full_ready", 32'(req_ready), 32'd0);
      checkOutput("full_count", 32'(count), 32'd4);

      // A fifth request held while FULL must never be taken.
      req_op = 4'd0; req_cond = 4'hE; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      checkOutput("full_hold_count", 32'(count), 32'd4);
      checkOutput("full_hold_ready", 32'(req_ready), 32'd0);

      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      expPtr = 0;
      checkOutput("clr_full", 32'(full), 32'd0);
      checkOutput("clr_count", 32'(count), 32'd0);
      checkOutput("clr_ready", 32'(req_ready), 32'd1);

      applyStimulus(4'd0,  4'hE, 1'b1, 1'b1, 4'd0, 4'd3, 12'h0FF, 24'h0, 1'b1, 32'hE3B030FF);
      applyStimulus(4'd4,  4'h0, 1'b0, 1'b1, 4'd4, 4'd5, 12'h003, 24'h0, 1'b1, 32'h00545003);
      applyStimulus(4'd12, 4'hE, 1'b1, 1'b1, 4'd2, 4'd6, 12'h010, 24'h0, 1'b1, 32'hE4826010);
      applyStimulus(4'd10, 4'h1, 1'b1, 1'b0, 4'd7, 4'd9, 12'h0AB, 24'h0, 1'b1, 32'h131700AB);
      @(posedge clk);
      #1;
      checkOutput("full_again", 32'(full), 32'd1);

      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      expPtr = 0;

      // clr landing on a WRITE cycle: the write still strobes at addr 0, pointer stays put.
      applyStimulus(4'd1, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 12'h004, 24'h0, 1'b1, 32'hE1E12004);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      expPtr = 0;
      checkOutput("clr_write_count", 32'(count), 32'd0);
      checkOutput("clr_write_addr", imem_addr, 32'h0);

      applyStimulus(4'd7, 4'hE, 1'b0, 1'b0, 4'd1, 4'd1, 12'h002, 24'h0, 1'b1, 32'hE1811002);
      @(posedge clk);
      #1;
      checkOutput("hold_wdata", imem_wdata, 32'hE1811002);
      checkOutput("hold_we", 32'(imem_we), 32'd0);
      checkOutput("count_after_orr", 32'(count), 32'd1);

      // Reset in the middle of a WRITE cycle drops the strobe at once and clears the pointer.
      applyStimulus(4'd8, 4'hE, 1'b1, 1'b1, 4'd4, 4'd4, 12'h001, 24'h0, 1'b0, 32'h0);
      errPending--;
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_we", 32'(imem_we), 32'd0);
      checkOutput("rst_mid_count", 32'(count), 32'd0);
      checkOutput("rst_mid_wdata", imem_wdata, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expPtr = 0;
      #1;
      checkOutput("rst_mid_addr", imem_addr, 32'h0);
      checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);

      applyStimulus(4'd3, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 12'h003, 24'h0, 1'b1, 32'hE0B12003);
      applyStimulus(4'd5, 4'hE, 1'b1, 1'b0, 4'd0, 4'd0, 12'h000, 24'h0, 1'b1, 32'hE2C00000);
      applyStimulus(4'd6, 4'hE, 1'b0, 1'b1, 4'd2, 4'd3, 12'h004, 24'h0, 1'b1, 32'hE0123004);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("final_count", 32'(count), 32'd3);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      checkOutput("err_drained", 32'(errPending), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
